// File: rtl/mux_arbiter.sv
// mux_arbiter: two-source arbiter owning the select of an 8-bit 2:1 mux,
// with a minimum grant dwell and a registered output word.
// Optional build macro: MUX_ARB_FIXED_PRI_EN gives source A fixed priority
// instead of round-robin.
module mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [1:0]       Req,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic [1:0]       Grant,
    output logic             Sel,
    output logic [WIDTH-1:0] Out,
    output logic             Valid,
    output logic             Switch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

    state_t     state;
    state_t     nxt;
    logic [7:0] cnt;
    logic       expired;
    logic       enter;
    logic       take_a;
    logic       take_b;

`ifndef MUX_ARB_FIXED_PRI_EN
    logic       last_b;
`endif

    assign expired = (cnt == 8'd0);
    assign enter   = (nxt != state) && (nxt != IDLE);

`ifdef MUX_ARB_FIXED_PRI_EN
    // A wins every arbitration point it requests; B only when A is quiet
    always_comb begin
        take_a = Req[0];
        take_b = Req[1] & ~Req[0];
    end
`else
    // on contention the source that did not hold the grant last wins
    always_comb begin
        take_a = Req[0] & (~Req[1] | last_b);
        take_b = Req[1] & (~Req[0] | ~last_b);
    end
`endif

    // next grant: free choice in IDLE or once the dwell has run out
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (take_a) begin
                    nxt = GNT_A;
                end else if (take_b) begin
                    nxt = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (expired) begin
                    if (take_a) begin
                        nxt = GNT_A;
                    end else if (take_b) begin
                        nxt = GNT_B;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // state, dwell counter and all registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            Grant  <= 2'b00;
            Sel    <= 1'b0;
            Out    <= '0;
            Valid  <= 1'b0;
            Switch <= 1'b0;
`ifndef MUX_ARB_FIXED_PRI_EN
            last_b <= 1'b1;
`endif
        end else begin
            state <= nxt;
            Grant <= {nxt == GNT_B, nxt == GNT_A};

            // reload only on a fresh grant; a kept grant re-arbitrates each cycle
            if (enter) begin
                cnt <= CNT_LOAD;
            end else if (!expired) begin
                cnt <= cnt - 8'd1;
            end

            if (nxt != IDLE) begin
                Sel <= (nxt == GNT_B);
            end

`ifndef MUX_ARB_FIXED_PRI_EN
            if (enter) begin
                last_b <= (nxt == GNT_B);
            end
`endif

            Switch <= ((state == GNT_A) && (nxt == GNT_B)) ||
                      ((state == GNT_B) && (nxt == GNT_A));

            // data follows the select that was already in effect this cycle
            if (state != IDLE) begin
                Out   <= Sel ? DataB : DataA;
                Valid <= 1'b1;
            end else begin
                Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: vector table, directed corner sequences and random
// stimulus against a grant-ownership model for DWELL=4 and DWELL=1.
module tb_mux_arbiter;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic [1:0] Req    = 2'b00;
    logic [7:0] DataA  = 8'h00;
    logic [7:0] DataB  = 8'h00;

    logic [1:0] g0, g1;
    logic       s0, s1;
    logic [7:0] o0, o1;
    logic       v0, v1;
    logic       w0, w1;

    mux_arbiter #(.WIDTH(8), .DWELL(4)) u_dut (
        .Clock(Clock), .Resetn(Resetn), .Req(Req),
        .DataA(DataA), .DataB(DataB),
        .Grant(g0), .Sel(s0), .Out(o0), .Valid(v0), .Switch(w0)
    );

    mux_arbiter #(.WIDTH(8), .DWELL(1)) u_dut1 (
        .Clock(Clock), .Resetn(Resetn), .Req(Req),
        .DataA(DataA), .DataB(DataB),
        .Grant(g1), .Sel(s1), .Out(o1), .Valid(v1), .Switch(w1)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;

    // model: owner 0=none 1=A 2=B, age = cycles the current grant has run
    int         dw[2] = '{4, 1};
    int         m_own[2];
    int         m_age[2];
    int         m_last[2];
    logic       m_sel[2];
    logic [7:0] m_out[2];
    logic       m_val[2];
    logic       m_sw[2];
    int         m_cyc = 0;

    typedef struct {
        logic [1:0] req;
        logic [7:0] da;
        logic [1:0] g;
        logic [7:0] o;
        logic       v;
    } vec_t;

    vec_t tbl[7];

    function automatic int pick(logic [1:0] r, int last);
`ifdef MUX_ARB_FIXED_PRI_EN
        if (r[0]) return 1;
        if (r[1]) return 2;
        return 0;
`else
        if (r == 2'b11) return (last == 1) ? 2 : 1;
        if (r[0]) return 1;
        if (r[1]) return 2;
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = 0;
            m_age[k]  = 0;
            m_last[k] = 2;
            m_sel[k]  = 1'b0;
            m_out[k]  = 8'h00;
            m_val[k]  = 1'b0;
            m_sw[k]   = 1'b0;
        end
    endtask

    task automatic model_step(int k);
        int prev;
        int nw;
        prev = m_own[k];
        if (prev != 0) begin
            m_out[k] = m_sel[k] ? DataB : DataA;
            m_val[k] = 1'b1;
        end else begin
            m_val[k] = 1'b0;
        end
        nw = prev;
        if (prev == 0 || m_age[k] >= dw[k]) nw = pick(Req, m_last[k]);
        if (nw != prev) begin
            m_age[k] = 1;
            if (nw != 0) m_last[k] = nw;
        end else begin
            m_age[k] = m_age[k] + 1;
        end
        m_sw[k] = (prev != 0) && (nw != 0) && (prev != nw);
        if (nw != 0) m_sel[k] = (nw == 2);
        m_own[k] = nw;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_model(int k, logic [1:0] g, logic s, logic [7:0] o,
                             logic v, logic w);
        logic [1:0] eg;
        eg = (m_own[k] == 1) ? 2'b01 : (m_own[k] == 2) ? 2'b10 : 2'b00;
        chk($sformatf("i%0d.grant@%0d", k, m_cyc), 32'(g), 32'(eg));
        chk($sformatf("i%0d.sel@%0d", k, m_cyc), 32'(s), 32'(m_sel[k]));
        chk($sformatf("i%0d.out@%0d", k, m_cyc), 32'(o), 32'(m_out[k]));
        chk($sformatf("i%0d.valid@%0d", k, m_cyc), 32'(v), 32'(m_val[k]));
        chk($sformatf("i%0d.switch@%0d", k, m_cyc), 32'(w), 32'(m_sw[k]));
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Resetn) begin
            model_step(0);
            model_step(1);
        end
        m_cyc++;
        @(negedge Clock);
        cmp_model(0, g0, s0, o0, v0, w0);
        cmp_model(1, g1, s1, o1, v1, w1);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        model_reset();
        tick();
        Resetn = 1'b1;
    endtask

    initial begin
        int sw0;
        int sw1;
        int exp_sw0;
        int exp_sw1;

        // single requester, DWELL=4: four grant cycles then idle, word held
        tbl[0] = '{req: 2'b01, da: 8'hA5, g: 2'b01, o: 8'h00, v: 1'b0};
        tbl[1] = '{req: 2'b00, da: 8'hA5, g: 2'b01, o: 8'hA5, v: 1'b1};
        tbl[2] = '{req: 2'b00, da: 8'hA5, g: 2'b01, o: 8'hA5, v: 1'b1};
        tbl[3] = '{req: 2'b00, da: 8'hA5, g: 2'b01, o: 8'hA5, v: 1'b1};
        tbl[4] = '{req: 2'b00, da: 8'hA5, g: 2'b00, o: 8'hA5, v: 1'b1};
        tbl[5] = '{req: 2'b00, da: 8'hA5, g: 2'b00, o: 8'hA5, v: 1'b0};
        tbl[6] = '{req: 2'b00, da: 8'hA5, g: 2'b00, o: 8'hA5, v: 1'b0};

        // reset held with both requesting
        model_reset();
        Resetn = 1'b0;
        Req    = 2'b11;
        DataA  = 8'h5A;
        DataB  = 8'hC3;
        tick();
        tick();
        chk("rst.grant", 32'(g0), 32'h0);
        chk("rst.sel", 32'(s0), 32'h0);
        chk("rst.out", 32'(o0), 32'h0);
        chk("rst.valid", 32'(v0), 32'h0);
        chk("rst.switch", 32'(w0), 32'h0);
        Resetn = 1'b1;
        tick();
        chk("rel.grant", 32'(g0), 32'h1);
        chk("rel.grant_d1", 32'(g1), 32'h1);

        // table-driven single requester
        Req = 2'b00;
        do_reset();
        DataB = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            Req   = tbl[i].req;
            DataA = tbl[i].da;
            tick();
            chk($sformatf("tbl%0d.grant", i), 32'(g0), 32'(tbl[i].g));
            chk($sformatf("tbl%0d.out", i), 32'(o0), 32'(tbl[i].o));
            chk($sformatf("tbl%0d.valid", i), 32'(v0), 32'(tbl[i].v));
            chk($sformatf("tbl%0d.sel", i), 32'(s0), 32'h0);
            chk($sformatf("tbl%0d.switch", i), 32'(w0), 32'h0);
        end

        // continuous contention on both dwell settings
        Req = 2'b00;
        do_reset();
        Req   = 2'b11;
        DataA = 8'h11;
        DataB = 8'h22;
        sw0 = 0;
        sw1 = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            sw0 += int'(w0);
            sw1 += int'(w1);
        end
`ifdef MUX_ARB_FIXED_PRI_EN
        exp_sw0 = 0;
        exp_sw1 = 0;
`else
        exp_sw0 = 5;
        exp_sw1 = 23;
`endif
        chk("cont.switches_d4", 32'(sw0), 32'(exp_sw0));
        chk("cont.switches_d1", 32'(sw1), 32'(exp_sw1));

        // dropping A after a long hold hands over on the next edge
        Req = 2'b10;
        tick();
        chk("drop.grant", 32'(g0), 32'h2);
        chk("drop.switch", 32'(w0), 32'(exp_sw0 == 0 || (sw0 % 2) == 0));

        // asynchronous reset in the middle of a B grant
        Req = 2'b00;
        do_reset();
        Req   = 2'b10;
        DataB = 8'h5C;
        tick();
        tick();
        chk("mid.pre_grant", 32'(g0), 32'h2);
        chk("mid.pre_out", 32'(o0), 32'h5C);
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        chk("mid.grant", 32'(g0), 32'h0);
        chk("mid.sel", 32'(s0), 32'h0);
        chk("mid.out", 32'(o0), 32'h0);
        chk("mid.valid", 32'(v0), 32'h0);
        Req = 2'b11;
        tick();
        Resetn = 1'b1;
        tick();
        chk("mid.after_grant", 32'(g0), 32'h1);
        chk("mid.after_grant_d1", 32'(g1), 32'h1);

        // random request patterns with slowly changing requests
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) Req = 2'($urandom_range(0, 3));
            DataA = 8'($urandom);
            DataB = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
